// File: rtl/bcd_sseg_pkg.sv
// bcd_sseg_pkg: shared segment patterns (active-low a..g) and anode constants
package bcd_sseg_pkg;
    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [1:0] AN_OFF = 2'b11;
endpackage

// File: rtl/bcd_sseg_lut.sv
// bcd_sseg_lut: combinational 4-bit hex digit to active-low 7-segment pattern
module bcd_sseg_lut
    import bcd_sseg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/bcd_to_sseg.sv
// bcd_to_sseg: registered BCD/hex to 7-segment decoder, single lit digit
module bcd_to_sseg
    import bcd_sseg_pkg::*;
#(
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter logic [1:0] AN_PATTERN     = 2'b10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] BCD,
    output logic [6:0] SSeg,
    output logic [1:0] an
);
    logic [6:0] lut_seg;
    logic [6:0] seg_drive;
    // Reset blanks the display in whichever polarity the board uses.
    localparam logic [6:0] RST_SEG = SEG_ACTIVE_LOW ? SEG_BLANK : ~SEG_BLANK;

    bcd_sseg_lut u_lut (.bcd(BCD), .seg(lut_seg));

    assign seg_drive = SEG_ACTIVE_LOW ? lut_seg : ~lut_seg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            SSeg <= RST_SEG;
            an   <= AN_OFF;
        end else begin
            SSeg <= seg_drive;
            an   <= AN_PATTERN;
        end
    end
endmodule

// File: tb/tb_bcd_to_sseg.sv
// tb_bcd_to_sseg: directed checks of decode, latency, async reset and polarity
module tb_bcd_to_sseg;
    logic       clk;
    logic       reset;
    logic [3:0] BCD;
    logic [6:0] SSeg, SSeg_hi;
    logic [1:0] an, an_hi;
    int total = 0;
    int bad = 0;

    logic [6:0] exp_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    bcd_to_sseg dut (.clk(clk), .reset(reset), .BCD(BCD), .SSeg(SSeg), .an(an));
    bcd_to_sseg #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (.clk(clk), .reset(reset), .BCD(BCD), .SSeg(SSeg_hi), .an(an_hi));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b0;
        BCD = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (SSeg !== 7'b1111111 || an !== 2'b11) begin
                bad++;
                $display("FAIL reset_hold: SSeg=%b an=%b want 1111111 11", SSeg, an);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (SSeg !== 7'b0100100 || an !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: SSeg=%b an=%b want 0100100 10", SSeg, an);
        end
    endtask

    task automatic test_sweep(input int lo, input int hi, input string name);
        @(negedge clk);
        BCD = 4'(lo);
        for (int v = lo + 1; v <= hi + 1; v++) begin
            @(negedge clk);
            total++;
            if (SSeg !== exp_tab[v-1] || an !== 2'b10) begin
                bad++;
                $display("FAIL %s[%0d]: SSeg=%b an=%b want %b 10", name, v - 1, SSeg, an, exp_tab[v-1]);
            end
            if (v <= hi) BCD = 4'(v);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        BCD = 4'd8;
        @(negedge clk);
        total++;
        if (SSeg !== 7'b0000000) begin
            bad++;
            $display("FAIL async_pre: SSeg=%b want 0000000", SSeg);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (SSeg !== 7'b1111111 || an !== 2'b11) begin
            bad++;
            $display("FAIL async_assert: SSeg=%b an=%b want 1111111 11", SSeg, an);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (SSeg !== 7'b0000000 || an !== 2'b10) begin
            bad++;
            $display("FAIL async_release: SSeg=%b an=%b want 0000000 10", SSeg, an);
        end
    endtask

    task automatic test_countdown();
        logic [3:0] seq [11] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
        @(negedge clk);
        BCD = seq[0];
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            total++;
            if (SSeg !== exp_tab[seq[i-1]]) begin
                bad++;
                $display("FAIL countdown[%0d]: SSeg=%b want %b", i - 1, SSeg, exp_tab[seq[i-1]]);
            end
            if (i < 11) BCD = seq[i];
        end
    endtask

    task automatic test_polarity();
        @(negedge clk);
        BCD = 4'd1;
        @(negedge clk);
        total++;
        if (SSeg_hi !== 7'b0110000 || an_hi !== 2'b10) begin
            bad++;
            $display("FAIL polarity_one: SSeg=%b an=%b want 0110000 10", SSeg_hi, an_hi);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (SSeg_hi !== 7'b0000000 || an_hi !== 2'b11) begin
            bad++;
            $display("FAIL polarity_reset: SSeg=%b an=%b want 0000000 11", SSeg_hi, an_hi);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sweep(0, 9, "decimal");
        test_sweep(10, 15, "hex");
        test_async_reset();
        test_countdown();
        test_polarity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
